if_sramlike_fetch: RTL and testbench

Instruction-fetch front end of the cqu_mips pipeline. It owns the fetch PC, drives the sram-like instruction bus (req / addr_ok / data_ok), and presents one registered instruction per delivery to the decode stage. It sits directly upstream of decode. It absorbs bus latency, back-pressure from pipeline stalls, and PC redirects from branch/jump resolution. At most one bus request is outstanding at any time.

---
 rtl/if_sramlike_fetch.sv | 177 +++++++++++++++++
 tb/tb_if_sramlike_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_sramlike_fetch.sv
// Instruction-fetch front end: owns the fetch PC, drives the sram-like instruction
// bus with at most one request in flight, and registers one instruction per delivery.
//
// state | meaning
// RST   | first cycle after reset, no request
// REQ   | request fetch_pc (or deliver an adel bubble for a misaligned fetch_pc)
// WAIT  | request accepted, waiting for data_ok (word dropped if discard is set)
// HOLD  | word captured in hold_inst while decode stalls
module if_sramlike_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        adel
);

    typedef enum logic [1:0] {
        RST  = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [31:0] hold_inst, hold_inst_nxt;
    logic        discard, discard_nxt;
    logic        adel_sent, adel_sent_nxt;

    logic        dlv;
    logic        dlv_adel;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_inst;
    logic        pc_aligned;

    assign pc_aligned = (fetch_pc[1:0] == 2'b00);
    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_addr  = fetch_pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RST;
            fetch_pc  <= RESET_PC;
            req_pc    <= 32'd0;
            hold_inst <= 32'd0;
            discard   <= 1'b0;
            adel_sent <= 1'b0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            req_pc    <= req_pc_nxt;
            hold_inst <= hold_inst_nxt;
            discard   <= discard_nxt;
            adel_sent <= adel_sent_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        req_pc_nxt    = req_pc;
        hold_inst_nxt = hold_inst;
        discard_nxt   = discard;
        adel_sent_nxt = adel_sent;
        inst_req      = 1'b0;
        dlv           = 1'b0;
        dlv_adel      = 1'b0;
        dlv_pc        = req_pc;
        dlv_inst      = 32'd0;

        case (state)
            RST: begin
                state_nxt = REQ;
            end
            REQ: begin
                inst_req = pc_aligned;
                if (redirect_valid) begin
                    fetch_pc_nxt  = redirect_pc;
                    adel_sent_nxt = 1'b0;
                    // request accepted in the same cycle is already stale
                    if (pc_aligned && inst_addr_ok) begin
                        req_pc_nxt  = fetch_pc;
                        discard_nxt = 1'b1;
                        state_nxt   = WAIT;
                    end
                end else if (pc_aligned) begin
                    if (inst_addr_ok) begin
                        req_pc_nxt = fetch_pc;
                        state_nxt  = WAIT;
                    end
                end else if (!adel_sent && !stall) begin
                    dlv           = 1'b1;
                    dlv_adel      = 1'b1;
                    dlv_pc        = fetch_pc;
                    adel_sent_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_nxt  = redirect_pc;
                    adel_sent_nxt = 1'b0;
                    if (inst_data_ok) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ;
                    end else begin
                        discard_nxt = 1'b1;
                    end
                end else if (inst_data_ok) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = REQ;
                    end else if (!stall) begin
                        dlv          = 1'b1;
                        dlv_inst     = inst_rdata;
                        fetch_pc_nxt = req_pc + 32'd4;
                        state_nxt    = REQ;
                    end else begin
                        hold_inst_nxt = inst_rdata;
                        state_nxt     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    fetch_pc_nxt  = redirect_pc;
                    adel_sent_nxt = 1'b0;
                    state_nxt     = REQ;
                end else if (!stall) begin
                    dlv          = 1'b1;
                    dlv_inst     = hold_inst;
                    fetch_pc_nxt = req_pc + 32'd4;
                    state_nxt    = REQ;
                end
            end
            default: begin
                state_nxt = RST;
            end
        endcase
    end

    // Non-delivering unstalled edges load a nop bubble; pc_out keeps the last PC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_out     <= 32'd0;
            inst_out   <= 32'd0;
            inst_valid <= 1'b0;
            adel       <= 1'b0;
        end else if (!stall) begin
            if (dlv) begin
                pc_out     <= dlv_pc;
                inst_out   <= dlv_inst;
                inst_valid <= 1'b1;
                adel       <= dlv_adel;
            end else begin
                inst_out   <= 32'd0;
                inst_valid <= 1'b0;
                adel       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_sramlike_fetch.sv
// Directed bench for if_sramlike_fetch: bus responses driven by hand, expected
// values written out for each step.
module tb_if_sramlike_fetch;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        adel;

    int errors = 0;
    int checks = 0;

    if_sramlike_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .pc_out        (pc_out),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .adel          (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic a,
                           input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
        chk({tag, "_adel"},  {31'd0, adel},       {31'd0, a});
        chk({tag, "_pc"},    pc_out,              pc);
        chk({tag, "_inst"},  inst_out,            ins);
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        inst_rdata = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        #12;
        chk_out("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_req",  {31'd0, inst_req}, 32'd0);
        chk("rst_wr",   {31'd0, inst_wr}, 32'd0);
        chk("rst_size", {30'd0, inst_size}, 32'd2);

        // first fetch: addr_ok in request cycle, data_ok one cycle later
        tick(); rstn = 1'b1;
        tick();
        chk("f1_req", {31'd0, inst_req}, 32'd1);
        chk("f1_addr", inst_addr, 32'hBFC0_0000);
        inst_addr_ok = 1'b1;
        tick();
        chk("f1_wait_req", {31'd0, inst_req}, 32'd0);
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        tick();
        inst_data_ok = 1'b0;
        chk_out("f1", 1'b1, 1'b0, 32'hBFC0_0000, 32'h2408_0001);
        chk("f1_next_addr", inst_addr, 32'hBFC0_0004);
        chk("f1_next_req", {31'd0, inst_req}, 32'd1);

        // data_ok delayed by 3 cycles
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        chk("d3_bubble0", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("d3_bubble", {31'd0, inst_valid}, 32'd0);
            chk("d3_no_req", {31'd0, inst_req}, 32'd0);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'hAAAA_0004;
        tick();
        inst_data_ok = 1'b0;
        chk_out("d3", 1'b1, 1'b0, 32'hBFC0_0004, 32'hAAAA_0004);
        chk("d3_next_addr", inst_addr, 32'hBFC0_0008);

        // stall held across data_ok for 4 edges
        stall = 1'b1; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
        chk_out("st_w", 1'b1, 1'b0, 32'hBFC0_0004, 32'hAAAA_0004);
        tick();
        inst_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_out("st_h", 1'b1, 1'b0, 32'hBFC0_0004, 32'hAAAA_0004);
            chk("st_no_req", {31'd0, inst_req}, 32'd0);
            tick();
        end
        chk_out("st_h2", 1'b1, 1'b0, 32'hBFC0_0004, 32'hAAAA_0004);
        stall = 1'b0;
        tick();
        chk_out("st", 1'b1, 1'b0, 32'hBFC0_0008, 32'h1234_5678);
        chk("st_next_addr", inst_addr, 32'hBFC0_000C);
        chk("st_next_req", {31'd0, inst_req}, 32'd1);

        // redirect during WAIT
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0100;
        tick();
        redirect_valid = 1'b0;
        chk("rw_no_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        inst_data_ok = 1'b0;
        chk("rw_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("rw_req", {31'd0, inst_req}, 32'd1);
        chk("rw_addr", inst_addr, 32'hBFC0_0100);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C01_0100;
        tick();
        inst_data_ok = 1'b0;
        chk_out("rw", 1'b1, 1'b0, 32'hBFC0_0100, 32'h3C01_0100);

        // redirect coincident with addr_ok: stale response discarded
        inst_addr_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0200;
        tick();
        inst_addr_ok = 1'b0; redirect_valid = 1'b0;
        chk("ra_no_req", {31'd0, inst_req}, 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0001;
        tick();
        inst_data_ok = 1'b0;
        chk("ra_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("ra_req", {31'd0, inst_req}, 32'd1);
        chk("ra_addr", inst_addr, 32'hBFC0_0200);

        // redirect coincident with data_ok
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0002;
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0300;
        tick();
        inst_data_ok = 1'b0; redirect_valid = 1'b0;
        chk("rd_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("rd_req", {31'd0, inst_req}, 32'd1);
        chk("rd_addr", inst_addr, 32'hBFC0_0300);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_0300;
        tick();
        inst_data_ok = 1'b0;
        chk_out("rd", 1'b1, 1'b0, 32'hBFC0_0300, 32'h1111_0300);

        // misaligned redirect target -> single adel bubble, no request
        redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0102;
        tick();
        redirect_valid = 1'b0;
        chk("ad_no_req0", {31'd0, inst_req}, 32'd0);
        chk("ad_pre_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_out("ad", 1'b1, 1'b1, 32'hBFC0_0102, 32'd0);
        chk("ad_no_req1", {31'd0, inst_req}, 32'd0);
        tick();
        chk_out("ad_after", 1'b0, 1'b0, 32'hBFC0_0102, 32'd0);
        chk("ad_no_req2", {31'd0, inst_req}, 32'd0);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_addr", inst_addr, 32'hFFFF_FFFC);
        chk("wr_req", {31'd0, inst_req}, 32'd1);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0000_FFFC;
        tick();
        inst_data_ok = 1'b0;
        chk_out("wr", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_FFFC);
        chk("wr_next_addr", inst_addr, 32'h0000_0000);

        // reset mid-transaction, late data_ok ignored
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        rstn = 1'b0;
        #1;
        chk_out("mr", 1'b0, 1'b0, 32'd0, 32'd0);
        chk("mr_req", {31'd0, inst_req}, 32'd0);
        chk("mr_addr", inst_addr, 32'hBFC0_0000);
        tick();
        rstn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hBAD0_0003;
        tick();
        inst_data_ok = 1'b0;
        chk("mr_valid", {31'd0, inst_valid}, 32'd0);
        chk("mr_req2", {31'd0, inst_req}, 32'd1);
        chk("mr_addr2", inst_addr, 32'hBFC0_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
